// File: rtl/mips_defs_pkg.sv
// Shared MIPS pipeline definitions: reset PC, NOP encoding and fetch FSM state encoding.
package mips_defs;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef enum logic [1:0] {
    REQ  = ST_REQ,
    WAIT = ST_WAIT,
    HOLD = ST_HOLD
  } fetch_state_e;

endpackage

// File: rtl/f_fetch_unit_if.sv
// Request/ack instruction-memory port; master is the fetch unit, slave is the memory.
interface f_fetch_unit_if;
  import mips_defs::*;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ack);
endinterface

// File: rtl/f_fetch_unit.sv
// F-stage fetch unit: PC register, imem request FSM, stall hold buffer and the F/D register.
module f_fetch_unit
  import mips_defs::*;
#(
  parameter logic [31:0] PC_RESET       = PC_RESET_DEF,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [31:0]           nextPC,
  output logic [31:0]           F_pc,
  f_fetch_unit_if.master        imem,
  output logic [31:0]           D_instr,
  output logic [31:0]           D_pc,
  output logic                  D_valid,
  output logic                  fetch_busy,
  output logic                  pc_misalign,
  output logic                  imem_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  fetch_state_e  state;
  logic [31:0]   hold_buf;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] cnt_inc;
  logic          avail;
  logic          advance;
  logic [31:0]   word;

  assign imem.imem_req  = (state == REQ);
  assign imem.imem_addr = F_pc;

  // An ack arriving while HOLD is active is ignored; the buffered word wins.
  assign avail      = (((state == REQ) || (state == WAIT)) && imem.imem_ack) || (state == HOLD);
  assign advance    = avail && !stall;
  assign word       = (state == HOLD) ? hold_buf : imem.imem_rdata;
  assign fetch_busy = !avail;
  assign cnt_inc    = (wait_cnt == CW'(TIMEOUT_CYCLES)) ? wait_cnt : wait_cnt + CW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= REQ;
      F_pc         <= PC_RESET;
      D_instr      <= NOP_WORD;
      D_pc         <= '0;
      D_valid      <= 1'b0;
      hold_buf     <= '0;
      wait_cnt     <= '0;
      pc_misalign  <= 1'b0;
      imem_timeout <= 1'b0;
    end else begin
      if (advance) begin
        D_instr <= word;
        D_pc    <= F_pc;
        D_valid <= 1'b1;
        F_pc    <= nextPC;
        if (nextPC[1:0] != 2'b00) pc_misalign <= 1'b1;
      end

      case (state)
        REQ: begin
          if (imem.imem_ack) begin
            if (stall) begin
              hold_buf <= imem.imem_rdata;
              state    <= HOLD;
            end
          end else begin
            wait_cnt <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (imem.imem_ack) begin
            if (stall) begin
              hold_buf <= imem.imem_rdata;
              state    <= HOLD;
            end else begin
              state <= REQ;
            end
          end else begin
            wait_cnt <= cnt_inc;
            if (cnt_inc == CW'(TIMEOUT_CYCLES)) imem_timeout <= 1'b1;
          end
        end
        HOLD: begin
          if (!stall) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_f_fetch_unit.sv
// Directed bench for f_fetch_unit: zero-wait streaming, late ack, stall/hold, branch delay slot,
// misalign/timeout flags and async reset from WAIT.
module tb_f_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] nextPC;
  logic [31:0] F_pc, D_instr, D_pc;
  logic        D_valid, fetch_busy, pc_misalign, imem_timeout;

  logic        mem_auto, man_ack, npc_auto;
  logic [31:0] man_data, npc_man;
  int          tests = 0, fails = 0;
  int          req_cnt = 0;
  int          req_snap;

  f_fetch_unit_if bus();

  f_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .nextPC(nextPC), .F_pc(F_pc), .imem(bus.master),
    .D_instr(D_instr), .D_pc(D_pc), .D_valid(D_valid), .fetch_busy(fetch_busy),
    .pc_misalign(pc_misalign), .imem_timeout(imem_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // zero-wait memory acks its own request combinationally
  assign bus.imem_ack   = mem_auto ? bus.imem_req : man_ack;
  assign bus.imem_rdata = mem_auto ? memword(bus.imem_addr) : man_data;
  assign nextPC         = npc_auto ? F_pc + 32'd4 : npc_man;

  always @(posedge clk) if (bus.imem_req) req_cnt <= req_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; mem_auto = 1'b1; npc_auto = 1'b1;
    man_ack = 1'b0; man_data = '0; npc_man = '0;
    step(); step();
    tests++; if (F_pc !== 32'h3000) begin fails++; $display("FAIL reset_fpc got %h want %h", F_pc, 32'h3000); end
    tests++; if (D_valid !== 1'b0) begin fails++; $display("FAIL reset_dvalid got %b want 0", D_valid); end
    tests++; if (D_instr !== 32'h0) begin fails++; $display("FAIL reset_dinstr got %h want 0", D_instr); end
    tests++; if (bus.imem_req !== 1'b1) begin fails++; $display("FAIL reset_req got %b want 1", bus.imem_req); end
    tests++; if ({pc_misalign, imem_timeout} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b want 00", {pc_misalign, imem_timeout}); end
  endtask

  task automatic test_zero_wait();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (D_pc !== 32'h3000 + 32'(4 * i) || D_valid !== 1'b1 || D_instr !== memword(32'h3000 + 32'(4 * i))) begin
        fails++; $display("FAIL zw_stream%0d got pc %h v %b i %h want pc %h v 1", i, D_pc, D_valid, D_instr, 32'h3000 + 32'(4 * i));
      end
    end
    tests++; if (F_pc !== 32'h300C) begin fails++; $display("FAIL zw_fpc got %h want %h", F_pc, 32'h300C); end
  endtask

  task automatic test_late_ack();
    mem_auto = 1'b0; man_ack = 1'b0; req_snap = req_cnt;
    #1;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (fetch_busy !== 1'b1 || D_pc !== 32'h3008) begin
        fails++; $display("FAIL late_busy%0d got busy %b dpc %h want 1 %h", i, fetch_busy, D_pc, 32'h3008);
      end
      step();
    end
    man_ack = 1'b1; man_data = 32'hA5A5_0001;
    #1;
    tests++; if (fetch_busy !== 1'b0) begin fails++; $display("FAIL late_avail got %b want 0", fetch_busy); end
    step();
    man_ack = 1'b0;
    #1;
    tests++; if (D_pc !== 32'h300C || D_instr !== 32'hA5A5_0001) begin fails++; $display("FAIL late_d got %h/%h want 300c/a5a50001", D_pc, D_instr); end
    tests++; if (req_cnt - req_snap !== 1) begin fails++; $display("FAIL late_reqs got %0d want 1", req_cnt - req_snap); end
  endtask

  task automatic test_stall_hold();
    req_snap = req_cnt;
    man_ack = 1'b1; man_data = 32'h1111_1111; stall = 1'b1;
    #1;
    step();
    man_ack = 1'b1; man_data = 32'h2222_2222;  // stray ack while holding must be ignored
    #1;
    tests++; if (bus.imem_req !== 1'b0 || D_pc !== 32'h300C) begin fails++; $display("FAIL hold_req got req %b dpc %h want 0 300c", bus.imem_req, D_pc); end
    step();
    man_ack = 1'b0; stall = 1'b0;
    #1;
    tests++; if (fetch_busy !== 1'b0) begin fails++; $display("FAIL hold_avail got %b want 0", fetch_busy); end
    step();
    tests++; if (D_instr !== 32'h1111_1111 || D_pc !== 32'h3010) begin fails++; $display("FAIL hold_word got %h/%h want 11111111/3010", D_instr, D_pc); end
    tests++; if (req_cnt - req_snap !== 1) begin fails++; $display("FAIL hold_reqs got %0d want 1", req_cnt - req_snap); end
  endtask

  task automatic test_delay_slot();
    npc_auto = 1'b0; npc_man = 32'h3040; man_ack = 1'b0;
    #1;
    step(); step();
    tests++; if (D_pc !== 32'h3010 || D_instr !== 32'h1111_1111 || F_pc !== 32'h3014) begin
      fails++; $display("FAIL ds_hold got dpc %h di %h fpc %h want 3010 11111111 3014", D_pc, D_instr, F_pc);
    end
    man_ack = 1'b1; man_data = 32'h3333_3333;
    step();
    tests++; if (D_pc !== 32'h3014 || D_instr !== 32'h3333_3333) begin fails++; $display("FAIL ds_slot got %h/%h want 3014/33333333", D_pc, D_instr); end
    tests++; if (F_pc !== 32'h3040) begin fails++; $display("FAIL ds_target got %h want 3040", F_pc); end
  endtask

  task automatic test_misalign_timeout();
    npc_man = 32'h3042; man_ack = 1'b1; man_data = 32'h4444_4444;
    step();
    man_ack = 1'b0; npc_man = 32'h3044;
    #1;
    tests++; if (pc_misalign !== 1'b1 || F_pc !== 32'h3042) begin fails++; $display("FAIL mis_set got %b fpc %h want 1 3042", pc_misalign, F_pc); end
    step();  // enter WAIT
    for (int i = 0; i < 8; i++) step();
    tests++; if (imem_timeout !== 1'b0) begin fails++; $display("FAIL to_early got %b want 0", imem_timeout); end
    for (int i = 0; i < 9; i++) step();
    tests++; if (imem_timeout !== 1'b1) begin fails++; $display("FAIL to_set got %b want 1", imem_timeout); end
    tests++; if (pc_misalign !== 1'b1 || fetch_busy !== 1'b1) begin fails++; $display("FAIL mis_sticky got %b busy %b want 1 1", pc_misalign, fetch_busy); end
  endtask

  task automatic test_reset_in_wait();
    reset = 1'b1;
    #1;
    tests++; if (F_pc !== 32'h3000 || D_valid !== 1'b0 || D_pc !== 32'h0 || D_instr !== 32'h0) begin
      fails++; $display("FAIL rw_regs got fpc %h v %b dpc %h di %h want 3000 0 0 0", F_pc, D_valid, D_pc, D_instr);
    end
    tests++; if ({pc_misalign, imem_timeout, bus.imem_req} !== 3'b001) begin fails++; $display("FAIL rw_flags got %b want 001", {pc_misalign, imem_timeout, bus.imem_req}); end
    step();
    reset = 1'b0; mem_auto = 1'b1; npc_auto = 1'b1;
    #1;
    tests++; if (F_pc !== 32'h3000) begin fails++; $display("FAIL rw_fpc got %h want 3000", F_pc); end
    step();
    tests++; if (D_pc !== 32'h3000 || D_valid !== 1'b1) begin fails++; $display("FAIL rw_first got %h v %b want 3000 1", D_pc, D_valid); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_late_ack();
    test_stall_hold();
    test_delay_slot();
    test_misalign_timeout();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
